gate_bist_controller: RTL
=========================

Name: gate_bist_controller

Overview:
- Synthesizable built-in self-test engine for the small mux-built logic gates (AND/OR/XOR via 2:1 mux).
- Drives every input combination of a combinational gate under test in order, waits a settle time, then samples the gate output.
- Compares each sample against an expected truth table and reports pass/fail, the mismatch count and the first failing pattern.
- Sits beside a gate instance as its hardware stimulus/response end, replacing a hand-written simulation-only bench.

Parameters:
- N_IN, 2, number of gate inputs; patterns are 0 .. 2^N_IN-1.
- TRUTH, 4'b1000, expected output table of width 2^N_IN; bit i is the expected output for pattern i (default is AND).
- SETTLE, 1, idle cycles between applying a pattern and sampling; 0 is legal.

Ports:
- clk  input  1  Single clock; all logic on rising edge.
- rst  input  1  Reset is synchronous and active-high. Sampled on the clk rising edge only.
- start  input  1  Level-sampled request to run a test. Honoured in IDLE and DONE, ignored while busy.
- stim  output  N_IN  Stimulus to the gate under test; stim[N_IN-1] is the MSB (A for 2-input gates, B is bit 0).
- dut_y  input  1  Gate-under-test output, combinational from stim.
- busy  output  1  High in APPLY, WAIT and SAMPLE.
- done  output  1  High in DONE.
- pass  output  1  Valid when done=1: 1 if fail_count==0.
- fail_count  output  N_IN+1  Number of mismatching patterns; max 2^N_IN, so it never wraps.
- first_fail_valid  output  1  Set on the first mismatch of a run.
- first_fail_pattern  output  N_IN  Pattern of the first mismatch. Held until the next start or rst.

Behaviour:
- Reset: state=IDLE; stim, busy, done, pass, fail_count, first_fail_valid and first_fail_pattern are all 0.
- All outputs are registered or decoded from the state register; there is no combinational input-to-output path.
- IDLE, start=1 at edge E0: go to APPLY; pattern counter=0 (stim=0); clear fail_count, first_fail_*, pass and done.
- APPLY (1 cycle): stim holds the pattern counter and the settle counter loads SETTLE.
  - SETTLE>0: go to WAIT.
  - SETTLE=0: go to SAMPLE.
- WAIT: count down SETTLE cycles, then go to SAMPLE.
- SAMPLE (1 cycle): compare dut_y with TRUTH[pattern].
  - On mismatch: fail_count+1. If first_fail_valid=0, set it and capture the pattern.
  - Pattern == 2^N_IN-1: go to DONE.
  - Otherwise: pattern+1 and go to APPLY.
- DONE: done=1, busy=0, pass=(fail_count==0). stim holds the last pattern.
  - Stays in DONE until start=1, which restarts exactly as from IDLE; done drops on the next edge.
- Latency: each pattern takes SETTLE+2 cycles. done rises at edge E0 + 2^N_IN*(SETTLE+2). Default configuration: E0+12.
- start while busy: ignored, with no effect on the counter or results.
- rst mid-run (any state): next edge returns to reset values. Partial results are discarded; no done pulse.
- rst and start together: rst wins.
- dut_y is sampled only in SAMPLE; its value in other states is don't-care. stim is stable for at least SETTLE+1 cycles before the sample.

Decomposition:
- Shared package/header gate_bist_pkg holds:
  - state encodings IDLE/APPLY/WAIT/SAMPLE/DONE (3-bit localparams);
  - standard truth-table constants TT_AND2=4'b1000, TT_OR2=4'b1110, TT_XOR2=4'b0110, TT_NAND2=4'b0111.
- One natural sub-module: gate_bist_settle_timer, a loadable down-counter with a zero flag, used for WAIT.
- The pattern counter and compare logic stay in the top.

Test Plan:
- Correct AND gate (defaults); start pulsed at E0:
  - stim steps 00,01,10,11, each held 3 cycles;
  - done=1 after edge E0+12; pass=1, fail_count=0, first_fail_valid=0.
- OR gate as DUT with TRUTH=TT_AND2 -> fail_count=2, pass=0, first_fail_valid=1, first_fail_pattern=01.
- Stuck-at-0 dut_y with TRUTH=TT_AND2 -> fail_count=1, first_fail_pattern=11, pass=0.
- rst asserted one cycle while stim=10 -> next edge all outputs 0, state IDLE; a following start runs a full correct pass (pass=1 at +12).
- start held high during a run -> no restart, done still at E0+12; start in DONE -> done=0 next edge, fresh run, results cleared.
- SETTLE=0, N_IN=2, TRUTH=TT_XOR2 with an XOR DUT -> done after edge E0+8, pass=1; with an AND DUT instead -> fail_count=3, first_fail_pattern=01.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared definitions for the mux-built gate BIST engine: FSM state encoding and
// the standard two-input truth tables (bit i is the output for pattern i).
package gate_bist_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StApply  = 3'd1,
        StWait   = 3'd2,
        StSample = 3'd3,
        StDone   = 3'd4
    } state_t;

    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_bist_settle_timer.sv
// Loadable down-counter with a zero flag; paces the settle interval between
// applying a stimulus pattern and sampling the gate output.
module gate_bist_settle_timer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/gate_bist_controller.sv
// BIST engine for a small combinational gate: walks every input pattern, waits
// SETTLE cycles, samples dut_y and tallies mismatches against TRUTH.
module gate_bist_controller
    import gate_bist_pkg::*;
#(
    parameter int unsigned           N_IN   = 2,
    parameter logic [2**N_IN-1:0]    TRUTH  = TT_AND2,
    parameter int unsigned           SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_pattern
);

    // The timer is loaded with SETTLE-1 so that its zero flag marks the last WAIT cycle.
    localparam int unsigned     TW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [TW-1:0]   SETTLE_LOAD = TW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [N_IN-1:0] LAST_PAT    = {N_IN{1'b1}};

    state_t          state_q;
    logic            settle_zero;
    logic            mismatch;
    logic [N_IN:0]   fail_inc;

    gate_bist_settle_timer #(
        .WIDTH (TW)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == StApply),
        .load_val (SETTLE_LOAD),
        .dec      (state_q == StWait),
        .zero     (settle_zero)
    );

    assign mismatch = (dut_y != TRUTH[stim]);
    assign fail_inc = fail_count + (N_IN + 1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= StIdle;
            stim               <= '0;
            fail_count         <= '0;
            first_fail_valid   <= 1'b0;
            first_fail_pattern <= '0;
            pass               <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q            <= StApply;
                        stim               <= '0;
                        fail_count         <= '0;
                        first_fail_valid   <= 1'b0;
                        first_fail_pattern <= '0;
                        pass               <= 1'b0;
                    end
                end
                StApply: begin
                    state_q <= (SETTLE == 0) ? StSample : StWait;
                end
                StWait: begin
                    if (settle_zero) begin
                        state_q <= StSample;
                    end
                end
                StSample: begin
                    if (mismatch) begin
                        fail_count <= fail_inc;
                        if (!first_fail_valid) begin
                            first_fail_valid   <= 1'b1;
                            first_fail_pattern <= stim;
                        end
                    end
                    if (stim == LAST_PAT) begin
                        state_q <= StDone;
                        pass    <= (fail_count == '0) && !mismatch;
                    end else begin
                        stim    <= stim + N_IN'(1);
                        state_q <= StApply;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = (state_q == StApply) || (state_q == StWait) || (state_q == StSample);
    assign done = (state_q == StDone);

endmodule
